// File: rtl/ula_controle_mdu.sv
// ---------------------------------------------------------------------------
// ula_controle_mdu
//   Issue-side partner of the 32-bit ULA. Decodes MIPS ALU requests into a
//   registered 4-bit ULA operation code and runs MULT/MULTU/DIV/DIVU on an
//   iterative engine (shift-add multiplier, restoring divider) that owns the
//   HI/LO registers and serves MFHI/MFLO.
//
//   Optional feature macro: MDU_EARLY_TERM_EN
//     defined   -> multiply leaves MUL as soon as the remaining multiplier
//                  bits are all zero (latency depends on the multiplier)
//     undefined -> fixed 34-cycle latency for every multiply and divide
//
// Ports
//   clock, reset_n        clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   request handshake, in_ready only in IDLE
//   alu_op, funct         decoded control fields
//   rs_val, rt_val        operands A and B
//   op_ula                registered ULA operation code
//   out_valid             one-cycle result pulse
//   mdu_sel               with out_valid: result is on mdu_result
//   mdu_result            HI/LO readout or LO of a finished MULT/DIV
//   hi, lo                HI and LO registers
//   illegal               pulse alongside out_valid for unsupported requests
//   busy                  multi-cycle operation in progress
// ---------------------------------------------------------------------------
module ula_controle_mdu #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [3:0]  op_ula,
  output logic        out_valid,
  output logic        mdu_sel,
  output logic [31:0] mdu_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_ula_q, op_ula_d;
  logic        out_valid_q, out_valid_d;
  logic        mdu_sel_q, mdu_sel_d;
  logic        illegal_q, illegal_d;
  logic [31:0] mdu_result_q, mdu_result_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Engine datapath. For multiply acc is the 64-bit product; for divide
  // acc[63:32] is the partial remainder and acc[31:0] the dividend that
  // shifts out while quotient bits shift in. mplr holds multiplier/divisor.
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;    // negate product / quotient in FIX
  logic        rneg_q, rneg_d;  // negate remainder in FIX (dividend sign)

  logic        signed_op, a_neg, b_neg, early_done;
  logic [31:0] mag_a, mag_b, fix_q, fix_r;
  logic [32:0] trial;
  logic [63:0] fix_p;

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign op_ula     = op_ula_q;
  assign out_valid  = out_valid_q;
  assign mdu_sel    = mdu_sel_q;
  assign mdu_result = mdu_result_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign illegal    = illegal_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave a latch behind.
    state_d      = state_q;
    op_ula_d     = op_ula_q;
    out_valid_d  = 1'b0;
    mdu_sel_d    = 1'b0;
    illegal_d    = 1'b0;
    mdu_result_d = mdu_result_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplr_d       = mplr_q;
    cnt_d        = cnt_q;
    is_div_d     = is_div_q;
    neg_d        = neg_q;
    rneg_d       = rneg_q;

    // Signed variants have funct[0] = 0 (MULT 011000, DIV 011010).
    signed_op = ~funct[0];
    a_neg     = signed_op & rs_val[31];
    b_neg     = signed_op & rt_val[31];
    mag_a     = a_neg ? -rs_val : rs_val;
    mag_b     = b_neg ? -rt_val : rt_val;
    trial     = {acc_q[63:32], acc_q[31]} - {1'b0, mplr_q};
    fix_p     = neg_q  ? -acc_q         : acc_q;
    fix_q     = neg_q  ? -acc_q[31:0]   : acc_q[31:0];
    fix_r     = rneg_q ? -acc_q[63:32]  : acc_q[63:32];
`ifdef MDU_EARLY_TERM_EN
    early_done = (mplr_q == '0);
`else
    early_done = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          unique case (alu_op)
            2'b00: op_ula_d = 4'b0010;
            2'b01: op_ula_d = 4'b0110;
            2'b10: begin
              unique case (funct)
                6'b100000: op_ula_d = 4'b0010;
                6'b100010: op_ula_d = 4'b0110;
                6'b100100: op_ula_d = 4'b0000;
                6'b100101: op_ula_d = 4'b0001;
                6'b100111: op_ula_d = 4'b1100;
                6'b101010: op_ula_d = 4'b0111;
                6'b010000: begin
                  mdu_sel_d    = 1'b1;
                  mdu_result_d = hi_q;
                end
                6'b010010: begin
                  mdu_sel_d    = 1'b1;
                  mdu_result_d = lo_q;
                end
                6'b011000, 6'b011001: begin
                  out_valid_d = 1'b0;
                  acc_d       = '0;
                  mcand_d     = {32'd0, mag_a};
                  mplr_d      = mag_b;
                  cnt_d       = '0;
                  is_div_d    = 1'b0;
                  neg_d       = a_neg ^ b_neg;
                  rneg_d      = 1'b0;
                  state_d     = S_MUL;
                end
                6'b011010, 6'b011011: begin
                  if (rt_val == '0) begin
                    // Divide by zero skips the engine entirely.
                    mdu_sel_d    = 1'b1;
                    hi_d         = rs_val;
                    lo_d         = 32'hFFFF_FFFF;
                    mdu_result_d = 32'hFFFF_FFFF;
                    state_d      = S_DONE;
                  end else begin
                    out_valid_d = 1'b0;
                    acc_d       = {32'd0, mag_a};
                    mplr_d      = mag_b;
                    cnt_d       = '0;
                    is_div_d    = 1'b1;
                    neg_d       = a_neg ^ b_neg;
                    rneg_d      = a_neg;
                    state_d     = S_DIV;
                  end
                end
                default: begin
                  illegal_d = 1'b1;
                  op_ula_d  = 4'b0000;
                end
              endcase
            end
            default: begin
              illegal_d = 1'b1;
              op_ula_d  = 4'b0000;
            end
          endcase
        end
      end

      S_MUL: begin
        if (early_done) begin
          state_d = S_FIX;
        end else begin
          acc_d   = acc_q + (mplr_q[0] ? mcand_q : 64'd0);
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
        end
      end

      S_DIV: begin
        // Restoring step: keep the trial remainder only if it is non-negative.
        if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
        else            acc_d = {acc_q[62:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d         = fix_r;
          lo_d         = fix_q;
          mdu_result_d = fix_q;
        end else begin
          hi_d         = fix_p[63:32];
          lo_d         = fix_p[31:0];
          mdu_result_d = fix_p[31:0];
        end
        out_valid_d = 1'b1;
        mdu_sel_d   = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_ula_q     <= '0;
      out_valid_q  <= 1'b0;
      mdu_sel_q    <= 1'b0;
      illegal_q    <= 1'b0;
      mdu_result_q <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplr_q       <= '0;
      cnt_q        <= '0;
      is_div_q     <= 1'b0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_ula_q     <= op_ula_d;
      out_valid_q  <= out_valid_d;
      mdu_sel_q    <= mdu_sel_d;
      illegal_q    <= illegal_d;
      mdu_result_q <= mdu_result_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplr_q       <= mplr_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      neg_q        <= neg_d;
      rneg_q       <= rneg_d;
    end
  end

endmodule

// File: doc/ula_controle_mdu.md
Name: ula_controle_mdu

Overview:
- Issue-side partner of the 32-bit ULA: accepts decoded MIPS ALU requests, generates the registered 4-bit ULA operation code, and executes MULT/MULTU/DIV/DIVU iteratively.
- Iterative engine uses a shift-add multiplier and a restoring divider, with HI/LO registers and MFHI/MFLO readout.
- Sits between the main control unit and the ULA in the EX stage; stalls issue while a multi-cycle op runs.

Parameters:
- ITER, 32: multiply/divide iteration count (operand width); the design is only valid at 32.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- alu_op  input  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (use funct), 11 = illegal
- funct  input  6  R-type function field
- rs_val  input  32  operand A
- rt_val  input  32  operand B
- op_ula  output  4  registered ULA operation code
- out_valid  output  1  one-cycle pulse: op_ula / mdu_result valid
- mdu_sel  output  1  with out_valid, result comes from mdu_result, not the ULA
- mdu_result  output  32  HI (MFHI) or LO (MFLO)
- hi  output  32  HI register
- lo  output  32  LO register
- illegal  output  1  one-cycle pulse, same cycle as out_valid, for unsupported alu_op/funct
- busy  output  1  multi-cycle op in progress

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is synchronous, active-low, sampled on the clock edge.
- Reset values: all outputs 0; state IDLE; hi = lo = 0.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - in_valid while not ready is ignored; nothing is queued.
- States: IDLE, MUL, DIV, FIX, DONE.
- Simple ops, accepted in IDLE:
  - Mapping to op_ula:
    - alu_op 00 -> 0010
    - alu_op 01 -> 0110
    - funct 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 100111 -> 1100
    - 101010 -> 0111
  - op_ula is registered; out_valid pulses in cycle N+1 for accept in cycle N.
  - mdu_sel = 0. State remains IDLE; back-to-back accepts every cycle are allowed.
- MFHI (010000) / MFLO (010010):
  - mdu_result = hi or lo in cycle N+1; out_valid = 1, mdu_sel = 1.
  - op_ula holds its previous value.
- MULT 011000 / MULTU 011001:
  - Accept latches operand magnitudes (absolute value for signed) and the result sign; go to MUL; busy = 1.
  - Runs ITER cycles of shift-add over a 64-bit accumulator, then FIX for one cycle (two's-complement negate if signed and signs differ), then DONE.
  - In DONE: {hi, lo} written, out_valid = 1, mdu_sel = 1, mdu_result = lo; then back to IDLE.
  - Latency from accept to out_valid is 34 cycles.
- DIV 011010 / DIVU 011011:
  - Restoring division, same timing (34 cycles).
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed -> lo = 0x80000000, hi = 0.
- Divide by zero (rt_val == 0): no iteration; go directly to DONE.
  - lo = 0xFFFFFFFF, hi = rs_val; out_valid in cycle N+1.
- Illegal (alu_op 11 or unlisted funct):
  - out_valid and illegal pulse in cycle N+1; op_ula = 0000; hi/lo unchanged.
- Reset mid-operation: aborts the engine immediately; hi/lo cleared; in_ready = 1 next cycle.
- hi/lo change only in DONE (or on reset).

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- Defined:
  - In MUL, when the remaining unshifted multiplier bits are all zero, skip directly to FIX. Latency = 3 + (index of highest set multiplier-magnitude bit) + 1; a zero multiplier gives latency 3.
  - Results are identical to the non-early-terminated path.
- Undefined: fixed 34-cycle latency for all multiplies. DIV is unaffected in both builds.

Test Plan:
- Reset, then R-type funct 100101 with in_valid -> next cycle op_ula = 0001, out_valid = 1, mdu_sel = 0; three back-to-back accepts give three consecutive pulses.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 -> after 34 cycles hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high throughout; in_valid during busy is ignored. Then MFHI -> mdu_result = 0xFFFFFFFF.
- DIVU 100/7 -> lo = 14, hi = 2. DIV -7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV 5/0 -> out_valid in the cycle after accept, lo = 0xFFFFFFFF, hi = 5.
- Start MULTU, deassert reset_n at iteration 10 -> next cycle hi = lo = 0, in_ready = 1, no out_valid.
- With MDU_EARLY_TERM_EN, MULTU 9×2 -> lo = 18, out_valid 5 cycles after accept; a build without the macro gives 34 cycles.
- alu_op 10, funct 000111 -> illegal = 1 and out_valid = 1 next cycle, hi/lo unchanged.
